// File: rtl/expand_bits.sv
// expand_bits: widens IW-bit signed samples to OW-bit signed samples on a
// valid/ready stream using one of four LSB fill / extension rules.
// A registered output stage and a one-entry skid buffer give full throughput
// with a registered in_ready.
//
// Build option: define EXPAND_BITS_DITHER_EN to include the 16-bit LFSR and
// the DITHER_FILL rule. When it is undefined there is no LFSR, and TYPE=2
// falls back to MID_FILL.

module expand_bits #(
    parameter int TYPE = 0,
    parameter int IW   = 12,
    parameter int OW   = IW + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out,
    output logic          out_valid,
    input  logic          out_ready
);

    // Number of bits added below (or above, for sign extension) the sample.
    localparam int D = OW - IW;

    // Fill pattern that lands in the centre of the truncation bin: 100...0.
    localparam logic [D-1:0] MID_PAT = D'(1) << (D - 1);

    // Rule encodings.
    localparam int T_ZERO  = 0;
    localparam int T_MID   = 1;
    localparam int T_DITH  = 2;
    localparam int T_SIGN  = 3;

    // Storage: output register plus one skid entry.
    logic [OW-1:0] out_q,  out_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;

    // Handshake events on this cycle.
    logic          in_xfer;
    logic          out_xfer;

    // Widened version of the incoming sample.
    logic [OW-1:0] wide;

    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid_q && out_ready;

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef EXPAND_BITS_DITHER_EN
    // Galois LFSR supplying the dither bits.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0] lfsr_q, lfsr_d;

    // Advance the LFSR once for every accepted sample, hold otherwise.
    always_comb begin
        lfsr_d = lfsr_q;
        if (in_xfer) begin
            if (lfsr_q[0]) begin
                lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
            end else begin
                lfsr_d = lfsr_q >> 1;
            end
        end
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Compute the wide value for the selected rule from the live input.
    always_comb begin
        wide = {in, {D{1'b0}}};
        case (TYPE)
            T_ZERO: wide = {in, {D{1'b0}}};
            T_MID:  wide = {in, MID_PAT};
`ifdef EXPAND_BITS_DITHER_EN
            T_DITH: wide = {in, lfsr_q[D-1:0]};
`else
            T_DITH: wide = {in, MID_PAT};
`endif
            T_SIGN: wide = {{D{in[IW-1]}}, in};
            default: wide = {in, {D{1'b0}}};
        endcase
    end

    // Route accepted samples through output register and skid in order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (in_xfer) begin
            if (skid_valid_q && out_xfer) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = wide;
                skid_valid_d = 1'b1;
            end else if (!out_valid_q || out_xfer) begin
                out_d        = wide;
                out_valid_d  = 1'b1;
            end else begin
                skid_d       = wide;
                skid_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        in_ready_d = !skid_valid_d;
    end

    // Datapath and handshake registers; reset drops every held sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_expand_bits.sv
// Bench for expand_bits: four instances (TYPE 0..3, IW=12, OW=16) share one
// input stream; a queue of expected wide values is filled on every accepted
// sample and drained on every output transfer.

module tb_expand_bits;

    logic        clk;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [15:0] out_w       [4];
    logic        out_valid_w [4];
    logic        in_ready_w  [4];

    typedef struct packed {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e3;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] lfsr_m;
    int          checks;
    int          passes;

    expand_bits #(.TYPE(0), .IW(12), .OW(16)) dut0 (
        .clk(clk), .rst(rst), .in(in_data), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .out(out_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready));
    expand_bits #(.TYPE(1), .IW(12), .OW(16)) dut1 (
        .clk(clk), .rst(rst), .in(in_data), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .out(out_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready));
    expand_bits #(.TYPE(2), .IW(12), .OW(16)) dut2 (
        .clk(clk), .rst(rst), .in(in_data), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .out(out_w[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready));
    expand_bits #(.TYPE(3), .IW(12), .OW(16)) dut3 (
        .clk(clk), .rst(rst), .in(in_data), .in_valid(in_valid), .in_ready(in_ready_w[3]),
        .out(out_w[3]), .out_valid(out_valid_w[3]), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic exp_t make_exp(input logic [11:0] d, input logic [15:0] m);
        exp_t e;
        e.e0 = {d, 4'b0000};
        e.e1 = {d, 4'b1000};
`ifdef EXPAND_BITS_DITHER_EN
        e.e2 = {d, m[3:0]};
`else
        e.e2 = {d, 4'b1000};
`endif
        e.e3 = {{4{d[11]}}, d};
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare every instance against the model state
    task automatic checkOutput();
        exp_t e;
        logic exp_ov;
        logic exp_ir;
        exp_ov = (sb.size() > 0);
        exp_ir = (sb.size() < 2);
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("out_valid[%0d]", i), {15'b0, out_valid_w[i]}, {15'b0, exp_ov});
            checkVal($sformatf("in_ready[%0d]", i), {15'b0, in_ready_w[i]}, {15'b0, exp_ir});
        end
        if (exp_ov) begin
            e = sb[0];
            checkVal("out[zero]",   out_w[0], e.e0);
            checkVal("out[mid]",    out_w[1], e.e1);
            checkVal("out[dither]", out_w[2], e.e2);
            checkVal("out[sign]",   out_w[3], e.e3);
        end
    endtask

    // Drive one cycle, check current state, then advance the model
    task automatic applyStimulus(input logic v, input logic [11:0] d, input logic ordy);
        logic in_x;
        logic out_x;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        checkOutput();
        in_x  = v && (sb.size() < 2);
        out_x = ordy && (sb.size() > 0);
        if (out_x) void'(sb.pop_front());
        if (in_x) begin
            sb.push_back(make_exp(d, lfsr_m));
            lfsr_m = lfsr_step(lfsr_m);
        end
    endtask

    // Assert reset asynchronously and check its immediate effect
    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("rst_out[%0d]", i), out_w[i], 16'h0000);
            checkVal($sformatf("rst_out_valid[%0d]", i), {15'b0, out_valid_w[i]}, 16'h0000);
            checkVal($sformatf("rst_in_ready[%0d]", i), {15'b0, in_ready_w[i]}, 16'h0001);
        end
        sb.delete();
        lfsr_m = 16'hACE1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        lfsr_m    = 16'hACE1;

        applyReset();

        // Dither sequence straight after reset: LFSR ACE1 then E270
        applyStimulus(1'b1, 12'h123, 1'b1);
        applyStimulus(1'b1, 12'h123, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);

        // Positive full-scale, one-cycle latency
        applyStimulus(1'b1, 12'h7FF, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);

        // Negative full-scale and zero back to back
        applyStimulus(1'b1, 12'h800, 1'b1);
        applyStimulus(1'b1, 12'h000, 1'b1);
        applyStimulus(1'b1, 12'h7FF, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);

        // Backpressure: 1 and 2 absorbed, 3 held off, then drain
        applyStimulus(1'b1, 12'h001, 1'b0);
        applyStimulus(1'b1, 12'h002, 1'b0);
        applyStimulus(1'b1, 12'h003, 1'b0);
        applyStimulus(1'b1, 12'h003, 1'b0);
        applyStimulus(1'b1, 12'h003, 1'b1);
        applyStimulus(1'b1, 12'h003, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);

        // Fill the skid, then reset mid-stream
        applyStimulus(1'b1, 12'hABC, 1'b0);
        applyStimulus(1'b1, 12'h456, 1'b0);
        applyStimulus(1'b0, 12'h000, 1'b0);
        applyReset();
        applyStimulus(1'b1, 12'h123, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);

        // Mixed random traffic with random backpressure
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 12'h000, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
